i2s_dac_tx: RTL and testbench
=============================

// Module: i2s_dac_tx
// PURPOSE
//  I2S transmitter feeding the codec DAC pin (aud_dac_dat) from a buffered stream of stereo samples.
//  Codec is I2S master: aud_bclk and aud_dac_lrck are inputs, oversampled in the clkin_50 domain.
//  Upstream producer (SD/SDRAM playback path) pushes stereo frames via valid/ready into an internal FIFO.
//  Drives zeros and counts underruns when starved; never emits a partial frame.
// PARAMETERS
//  DW          16   sample width per channel, bits (8..32)
//  FIFO_DEPTH  8    stereo frames buffered; power of 2, >=2
//  UCNT_W      16   width of underrun counter
// PORTS
//  clkin_50      in   1           system clock, 50 MHz
//  rst_n         in   1           asynchronous active-low reset
//  sample_l      in   DW          left sample, two's complement
//  sample_r      in   DW          right sample, two's complement
//  sample_valid  in   1           frame on sample_l/r valid
//  sample_ready  out  1           FIFO can accept; push when valid&&ready
//  enable        in   1           playback enable
//  aud_bclk      in   1           codec bit clock (async)
//  aud_dac_lrck  in   1           codec DAC word clock (async); 0 = left
//  aud_dac_dat   out  1           serial DAC data
//  fifo_level    out  log2(D)+1   frames currently buffered
//  underrun_cnt  out  UCNT_W      frames substituted with zeros, saturating
//  clr_underrun  in   1           synchronous clear of underrun_cnt
// BEHAVIOUR
//  Reset (async): FIFO empty, fifo_level=0, sample_ready=0 during reset then 1 next clk, aud_dac_dat=0,
//   underrun_cnt=0, shift reg=0, bit_cnt=0, active=0, lrck_last=1, sync flops=0.
//  Sync: 2-FF synchronisers on aud_bclk, aud_dac_lrck; third flop on bclk for edge detect.
//   bclk_fall = prev&~cur (synced). Edge-to-action latency 3 clkin_50 cycles; requires BCLK <= 3.125 MHz.
//  FIFO: push when sample_valid&&sample_ready; sample_ready = !full. Pop+push same cycle: level unchanged.
//   Push ignored when full (ready low). Pointers wrap modulo FIFO_DEPTH with extra wrap bit.
//  Serializer, evaluated only on bclk_fall cycles; lrck_s sampled there:
//   - lrck_s != lrck_last (channel boundary): lrck_last<=lrck_s; aud_dac_dat<=0 (I2S 1-bit delay);
//     bit_cnt<=DW.
//     * Falling LRCK (left start): active<=enable. If active-next && !empty: pop, shreg<=sample_l,
//       hold_r<=sample_r. If active-next && empty: shreg<=0, hold_r<=0, underrun_cnt++ (saturate).
//       If !enable: shreg<=0, hold_r<=0, no pop, no count.
//     * Rising LRCK (right start): shreg<=hold_r.
//   - else if bit_cnt!=0: aud_dac_dat<=shreg[DW-1]; shreg<=shreg<<1; bit_cnt--.
//   - else: aud_dac_dat<=0 (pad bits when slot wider than DW).
//  Result: MSB appears on 2nd BCLK falling edge after LRCK transition, DW bits MSB-first, then zeros.
//  enable changes take effect only at next left boundary; a frame started is always completed.
//  First boundary after reset: a rising LRCK is treated as right start with hold_r=0 (outputs zeros).
//  clr_underrun and increment same cycle: clear wins (result 0).
//  underrun_cnt saturates at all-ones; no wrap.
//  Reset mid-frame: output forced 0 immediately; resumes at next left boundary after rst_n release.
//  Outputs fully registered; no combinational path from inputs to aud_dac_dat.
// STRUCTURE
//  Shared include audio_defs.vh: DW default, I2S_LEFT=1'b0 constant, FIFO depth default.
//  Sub-module: sync_fifo (param width 2*DW, depth FIFO_DEPTH; push/pop/full/empty/level,
//   async active-low reset). Serializer, synchronisers, counter stay in i2s_dac_tx.
// TESTING
//  Bench model of codec: BCLK 1.536 MHz, LRCK 48 kHz, 16 BCLK per channel, DW=16.
//  1. Push L=16'hA5C3, R=16'h0F01, enable=1 -> decoded L=A5C3, R=0F01; MSB on 2nd BCLK after LRCK edge.
//  2. No pushes, enable=1, 4 frames -> aud_dac_dat stays 0, underrun_cnt=4; clr_underrun -> 0.
//  3. Push 9 frames with DEPTH=8, no LRCK -> sample_ready=0 after 8, fifo_level=8; 9th held until pop.
//  4. Deassert enable mid-left-word -> current frame completes intact, next frames zero, no pops,
//     underrun_cnt unchanged; re-enable -> resumes at next left boundary with next queued frame.
//  5. Slot width 32 BCLK/channel, L=16'h8001 -> 16 data bits then 15 zero pad bits per channel.
//  6. Assert rst_n low mid-right-word -> aud_dac_dat=0 same cycle, fifo_level=0, underrun_cnt=0;
//     after release first valid frame output from next falling LRCK.

Source files
------------

// File: rtl/i2s_dac_tx_pkg.sv
// rtl/i2s_dac_tx_pkg.sv - shared defaults and serializer action codes for the I2S DAC transmitter
package i2s_dac_tx_pkg;

    localparam int DW_DEFAULT         = 16;
    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int UCNT_W_DEFAULT     = 16;

    // LRCK level that marks the left channel slot
    localparam logic I2S_LEFT = 1'b0;

    // What the serializer does on a given system clock cycle
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LEFT_START,
        ACT_RIGHT_START,
        ACT_SHIFT,
        ACT_PAD
    } ser_act_e;

endpackage

// File: rtl/i2s_dac_tx_sync_fifo.sv
// rtl/i2s_dac_tx_sync_fifo.sv - single-clock FIFO holding stereo frames for the I2S transmitter
module i2s_dac_tx_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC data transmitter slaved to codec BCLK/LRCK, with frame FIFO and underrun counter
module i2s_dac_tx
    import i2s_dac_tx_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int UCNT_W     = UCNT_W_DEFAULT
) (
    input  logic                          clkin_50,
    input  logic                          rst_n,
    input  logic [DW-1:0]                 sample_l,
    input  logic [DW-1:0]                 sample_r,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          enable,
    input  logic                          aud_bclk,
    input  logic                          aud_dac_lrck,
    output logic                          aud_dac_dat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [UCNT_W-1:0]             underrun_cnt,
    input  logic                          clr_underrun
);

    localparam int CW = $clog2(DW + 1);

    logic              bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic              lrck_s1_q, lrck_s2_q;
    logic              ready_q;
    logic [DW-1:0]     shreg_q, shreg_d;
    logic [DW-1:0]     hold_r_q, hold_r_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              active_q, active_d;
    logic              lrck_last_q, lrck_last_d;
    logic              dat_q, dat_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic              bclk_fall;
    logic              carry_bit;
    logic              pop;
    logic              underrun_inc;
    logic              fifo_full, fifo_empty;
    logic [2*DW-1:0]   fifo_rdata;
    ser_act_e          act;

    // Bring the codec clocks into clkin_50; third bclk flop gives the previous value for edge detect
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
        end else begin
            bclk_s1_q <= aud_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            lrck_s1_q <= aud_dac_lrck;
            lrck_s2_q <= lrck_s1_q;
        end
    end

    // Hold ready low while in reset and for the first cycle after it
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign bclk_fall    = bclk_s3_q & ~bclk_s2_q;
    assign sample_ready = ready_q & ~fifo_full;

    i2s_dac_tx_sync_fifo #(
        .W     (2 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clkin_50),
        .rst_n   (rst_n),
        .push_i  (sample_valid & sample_ready),
        .wdata_i ({sample_l, sample_r}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Classify the current cycle: channel boundary, data shift, pad bit, or nothing
    always_comb begin
        act = ACT_NONE;
        if (bclk_fall) begin
            if (lrck_s2_q != lrck_last_q) begin
                act = (lrck_s2_q == I2S_LEFT) ? ACT_LEFT_START : ACT_RIGHT_START;
            end else if (bit_cnt_q != '0) begin
                act = ACT_SHIFT;
            end else begin
                act = ACT_PAD;
            end
        end
    end

    // When the slot is exactly DW bits wide the LSB of the previous word lands in the
    // first bit time of the next slot; otherwise that bit time is the zero delay bit.
    assign carry_bit = (bit_cnt_q != '0) ? shreg_q[DW-1] : 1'b0;

    // Serializer next state, FIFO pop and underrun detection
    always_comb begin
        shreg_d      = shreg_q;
        hold_r_d     = hold_r_q;
        bit_cnt_d    = bit_cnt_q;
        active_d     = active_q;
        lrck_last_d  = lrck_last_q;
        dat_d        = dat_q;
        pop          = 1'b0;
        underrun_inc = 1'b0;
        case (act)
            ACT_LEFT_START: begin
                lrck_last_d = lrck_s2_q;
                dat_d       = carry_bit;
                bit_cnt_d   = CW'(DW);
                active_d    = enable;
                if (enable && !fifo_empty) begin
                    pop      = 1'b1;
                    shreg_d  = fifo_rdata[2*DW-1:DW];
                    hold_r_d = fifo_rdata[DW-1:0];
                end else begin
                    shreg_d      = '0;
                    hold_r_d     = '0;
                    underrun_inc = enable;
                end
            end
            ACT_RIGHT_START: begin
                lrck_last_d = lrck_s2_q;
                dat_d       = carry_bit;
                bit_cnt_d   = CW'(DW);
                shreg_d     = active_q ? hold_r_q : '0;
            end
            ACT_SHIFT: begin
                dat_d     = shreg_q[DW-1];
                shreg_d   = {shreg_q[DW-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 1'b1;
            end
            ACT_PAD: begin
                dat_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Underrun counter: clear has priority, saturates at all-ones
    always_comb begin
        ucnt_d = ucnt_q;
        if (clr_underrun) begin
            ucnt_d = '0;
        end else if (underrun_inc && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    // Serializer and counter registers; reset forces the data pin low immediately
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            hold_r_q    <= '0;
            bit_cnt_q   <= '0;
            active_q    <= 1'b0;
            lrck_last_q <= 1'b1;
            dat_q       <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            shreg_q     <= shreg_d;
            hold_r_q    <= hold_r_d;
            bit_cnt_q   <= bit_cnt_d;
            active_q    <= active_d;
            lrck_last_q <= lrck_last_d;
            dat_q       <= dat_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign aud_dac_dat  = dat_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx with a codec BCLK/LRCK model
module tb_i2s_dac_tx;

    logic        clkin_50     = 1'b0;
    logic        rst_n        = 1'b0;
    logic [15:0] sample_l     = '0;
    logic [15:0] sample_r     = '0;
    logic        sample_valid = 1'b0;
    logic        enable       = 1'b0;
    logic        aud_bclk     = 1'b1;
    logic        aud_dac_lrck = 1'b1;
    logic        clr_underrun = 1'b0;
    logic        sample_ready;
    logic        aud_dac_dat;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_cnt;

    int   checks   = 0;
    int   failures = 0;
    logic bits[$];

    i2s_dac_tx #(
        .DW         (16),
        .FIFO_DEPTH (8),
        .UCNT_W     (16)
    ) dut (
        .clkin_50     (clkin_50),
        .rst_n        (rst_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .enable       (enable),
        .aud_bclk     (aud_bclk),
        .aud_dac_lrck (aud_dac_lrck),
        .aud_dac_dat  (aud_dac_dat),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .clr_underrun (clr_underrun)
    );

    always #10 clkin_50 = ~clkin_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        @(negedge clkin_50);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        @(negedge clkin_50);
        sample_valid = 1'b0;
    endtask

    function automatic logic [15:0] word_at(input int base);
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[15-k] = bits[base+k];
        return w;
    endfunction

    function automatic logic any_one(input int lo, input int hi);
        logic a;
        a = 1'b0;
        for (int k = lo; k <= hi; k++) a = a | bits[k];
        return a;
    endfunction

    // Codec model: n frames of 2*slot bit times, plus one lead-out bit time with LRCK held high.
    // bits[j] is the data seen at the BCLK rising edge following falling edge j.
    // ev_kind 1 drops enable at fall ev_fall; ev_kind 2 pulses reset there.
    task automatic run_frames(input int n, input int slot, input int ev_fall, input int ev_kind);
        bits.delete();
        for (int j = 0; j <= 2 * slot * n; j++) begin
            @(negedge clkin_50);
            aud_bclk = 1'b0;
            if (j < 2 * slot * n) aud_dac_lrck = ((j % (2 * slot)) >= slot);
            if (j == ev_fall) begin
                if (ev_kind == 1) begin
                    enable = 1'b0;
                end else if (ev_kind == 2) begin
                    check("pre_reset_dat", aud_dac_dat, 1);
                    rst_n = 1'b0;
                    #1;
                    check("midreset_dat", aud_dac_dat, 0);
                    check("midreset_level", fifo_level, 0);
                    check("midreset_ucnt", underrun_cnt, 0);
                    check("midreset_ready", sample_ready, 0);
                    @(negedge clkin_50);
                    @(negedge clkin_50);
                    rst_n = 1'b1;
                end
            end
            repeat (15) @(negedge clkin_50);
            bits.push_back(aud_dac_dat);
            aud_bclk = 1'b1;
            repeat (16) @(negedge clkin_50);
        end
    endtask

    initial begin
        repeat (3) @(negedge clkin_50);
        check("reset_ready", sample_ready, 0);
        check("reset_level", fifo_level, 0);
        check("reset_ucnt", underrun_cnt, 0);
        check("reset_dat", aud_dac_dat, 0);
        rst_n = 1'b1;
        @(negedge clkin_50);
        check("ready_after_reset", sample_ready, 1);

        // single frame, 16-bit slots
        push(16'hA5C3, 16'h0F01);
        check("t1_level_push", fifo_level, 1);
        enable = 1'b1;
        run_frames(1, 16, -1, 0);
        check("t1_delay_bit", bits[0], 0);
        check("t1_msb_2nd_bclk", bits[1], 1);
        check("t1_left", word_at(1), 16'hA5C3);
        check("t1_right", word_at(17), 16'h0F01);
        check("t1_level_after", fifo_level, 0);
        check("t1_ucnt", underrun_cnt, 0);

        // starved playback
        run_frames(4, 16, -1, 0);
        check("t2_all_zero", any_one(0, bits.size() - 1), 0);
        check("t2_ucnt", underrun_cnt, 4);
        @(negedge clkin_50);
        clr_underrun = 1'b1;
        @(negedge clkin_50);
        clr_underrun = 1'b0;
        check("t2_ucnt_clr", underrun_cnt, 0);

        // fill to depth, ninth frame waits for a pop
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        check("t3_ready_full", sample_ready, 0);
        check("t3_level_full", fifo_level, 8);
        @(negedge clkin_50);
        sample_l     = 16'h1008;
        sample_r     = 16'h2008;
        sample_valid = 1'b1;
        repeat (4) @(negedge clkin_50);
        check("t3_level_held", fifo_level, 8);
        run_frames(1, 16, -1, 0);
        sample_valid = 1'b0;
        check("t3_left", word_at(1), 16'h1000);
        check("t3_right", word_at(17), 16'h2000);
        check("t3_level_refill", fifo_level, 8);

        // enable dropped mid-left-word
        run_frames(1, 16, -1, 0);
        check("t4_left_a", word_at(1), 16'h1001);
        check("t4_level_a", fifo_level, 7);
        run_frames(3, 16, 5, 1);
        check("t4_left_b", word_at(1), 16'h1002);
        check("t4_right_b", word_at(17), 16'h2002);
        check("t4_disabled_zero", any_one(33, bits.size() - 1), 0);
        check("t4_level_b", fifo_level, 6);
        check("t4_ucnt", underrun_cnt, 0);
        enable = 1'b1;
        run_frames(1, 16, -1, 0);
        check("t4_left_c", word_at(1), 16'h1003);
        check("t4_right_c", word_at(17), 16'h2003);
        check("t4_level_c", fifo_level, 5);

        // reset mid-right-word
        run_frames(1, 16, 20, 2);
        check("t6_left", word_at(1), 16'h1004);
        check("t6_zero_after_reset", any_one(20, 32), 0);
        check("t6_level", fifo_level, 0);
        check("t6_ucnt", underrun_cnt, 0);
        push(16'h1234, 16'h5678);
        run_frames(1, 16, -1, 0);
        check("t6_left_resume", word_at(1), 16'h1234);
        check("t6_right_resume", word_at(17), 16'h5678);
        check("t6_ucnt_resume", underrun_cnt, 0);

        // 32-bit slots: data then zero padding
        push(16'h8001, 16'h8001);
        run_frames(1, 32, -1, 0);
        check("t5_delay_bit", bits[0], 0);
        check("t5_left", word_at(1), 16'h8001);
        check("t5_left_pad", any_one(17, 32), 0);
        check("t5_right", word_at(33), 16'h8001);
        check("t5_right_pad", any_one(49, 64), 0);
        check("t5_level", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
